piso_shift_transmitter: RTL
===========================

Name: piso_shift_transmitter

Overview:
- Parallel-in, serial-out transmitter. It is the sending end for the team's 8-bit right-shift serial receiver.
- Accepts a WIDTH-bit word over a valid/ready handshake and drives it LSB-first onto serial line A, one bit per clock.
- A one-word holding buffer allows gapless back-to-back words, so a right-shift SIPO at the far end holds each word on its parallel output after WIDTH clocks.

Parameters:
- WIDTH, 8: word width in bits (legal range 2..32).
- LSB_FIRST, 1: 1 = bit 0 is sent first (matches the right-shift receiver); 0 = MSB first.

Ports:
- clock  in  1  single system clock, rising-edge active.
- clear  in  1  asynchronous, active-low reset.
- data_in  in  WIDTH  parallel word to transmit.
- load_valid  in  1  data_in is valid this cycle.
- load_ready  out  1  block can accept a word this cycle.
- A  out  1  serial data out.
- bit_valid  out  1  A carries a payload bit this cycle.
- last_bit  out  1  A carries the final bit of the current word.
- busy  out  1  a word is shifting or waiting in the hold buffer.

Behaviour:
- Reset (clear low, asynchronous): A=0, bit_valid=0, last_bit=0, busy=0, load_ready=1, hold buffer empty, bit counter=0, state=IDLE. Reset mid-word aborts the word silently. The first edge after clear rises behaves as from IDLE.
- Handshake: a transfer occurs on a rising edge where load_valid && load_ready. data_in is sampled only at that edge.
- load_ready = !hold_full. It is combinational from registered state and never depends on load_valid.
- State IDLE: A=0, bit_valid=0.
  - On a transfer, the word loads directly into the shift register, counter=0, and state goes to SHIFT.
  - Bit 0 (or bit WIDTH-1 when LSB_FIRST=0) appears on A in the cycle after the accepting edge, with bit_valid=1. Latency is 1 clock.
- State SHIFT: each edge advances the shift register by one position (right shift when LSB_FIRST=1) and increments the counter.
  - A is always the current shift-register end bit and is registered, with no combinational path from data_in.
  - last_bit=1 exactly when counter==WIDTH-1.
- Transfer in SHIFT with counter<WIDTH-1: the word goes into the hold buffer; hold_full=1, load_ready drops the next cycle.
- End-of-word edge (counter==WIDTH-1), in priority order:
  - hold_full: load the hold word into the shift register, counter=0, clear hold_full, stay in SHIFT. Next bit is the new word's first bit; no gap.
  - else transfer this edge (hold empty, so ready=1): load data_in directly into the shift register, stay in SHIFT, no gap.
  - else: go to IDLE. A=0, bit_valid=0, last_bit=0 next cycle.
- Transfer at the end-of-word edge while hold_full: impossible, because load_ready=0.
- busy = (state==SHIFT) || hold_full.
- Counter width is clog2(WIDTH). It wraps only by explicit reload to 0, never by overflow.
- Throughput: one word per WIDTH clocks sustained. Maximum buffering is 2 words (shift register + hold).

Test Plan:
- Reset then single word: after reset, load 8'hA5 at edge 1. A over edges 2-9 = 1,0,1,0,0,1,0,1 with bit_valid=1 and last_bit only in the 8th bit cycle. Then IDLE with A=0, bit_valid=0, load_ready=1 throughout.
- Loopback: feed A into an 8-bit right-shift SIPO model clocked by the same clock. Send 8'h3C. The SIPO output equals 8'h3C at the edge ending the last_bit cycle.
- Back-to-back: hold load_valid=1 with words 8'h01, 8'hFF, 8'h80.
  - 24 consecutive bit_valid cycles with no gap.
  - load_ready toggles low while hold is full.
  - Serial stream matches all three words LSB-first.
- End-edge direct load: hold empty, present 8'h55 only at the edge where last_bit=1 for the current word. The next cycle continues seamlessly with 8'h55's bit 0 (1); no IDLE cycle.
- Backpressure: during SHIFT load 8'h11 (fills hold), then keep load_valid=1 with 8'h22. 8'h22 is not accepted until load_ready returns high after the hold buffer drains; no word is lost or duplicated.
- Reset mid-operation: assert clear low asynchronously at bit 4 of 8'hF0 with the hold buffer full.
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - After release, the next word 8'h0F transmits cleanly; neither old word reappears.

Source files
------------

// File: rtl/piso_shift_transmitter_if.sv
// Load-side handshake bundle for the parallel-in serial-out transmitter.
// The producer drives the word and its valid flag; the transmitter answers with ready.
interface piso_shift_transmitter_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;

    modport master (
        output data_in,
        output load_valid,
        input  load_ready
    );

    modport slave (
        input  data_in,
        input  load_valid,
        output load_ready
    );
endinterface

// File: rtl/piso_shift_transmitter.sv
// Parallel-in, serial-out transmitter with a one-word hold buffer.
// Words are taken over a valid/ready handshake and shifted onto A one bit per
// clock. The hold buffer lets the next word start on the clock right after the
// current word's last bit, so a far-end shift receiver sees an unbroken stream.
module piso_shift_transmitter #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                      clock,
    input  logic                      clear,
    piso_shift_transmitter_if.slave   load_bus,
    output logic                      A,
    output logic                      bit_valid,
    output logic                      last_bit,
    output logic                      busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] shift_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_s;
    logic [WIDTH-1:0] hold_r;
    logic [WIDTH-1:0] hold_s;
    logic             hold_full_r;
    logic             hold_full_s;
    logic             xfer_s;
    logic             a_r;
    logic             bit_valid_r;
    logic             last_bit_r;
    logic             busy_r;

    // Bit that sits at the output end of the shift register for the chosen order.
    function automatic logic end_bit(input logic [WIDTH-1:0] word);
        if (LSB_FIRST) begin
            return word[0];
        end else begin
            return word[WIDTH-1];
        end
    endfunction

    // Shift register advanced by one position toward the output end.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] word);
        if (LSB_FIRST) begin
            return {1'b0, word[WIDTH-1:1]};
        end else begin
            return {word[WIDTH-2:0], 1'b0};
        end
    endfunction

    // Ready only reflects the hold buffer so it never loops back from load_valid.
    assign load_bus.load_ready = !hold_full_r;
    assign xfer_s              = load_bus.load_valid && !hold_full_r;

    assign A         = a_r;
    assign bit_valid = bit_valid_r;
    assign last_bit  = last_bit_r;
    assign busy      = busy_r;

    // Next-state logic: word loading, shifting, hold-buffer fill and drain.
    always_comb begin
        state_s     = state_r;
        shift_s     = shift_r;
        cnt_s       = cnt_r;
        hold_s      = hold_r;
        hold_full_s = hold_full_r;
        case (state_r)
            ST_IDLE: begin
                if (xfer_s) begin
                    shift_s = load_bus.data_in;
                    cnt_s   = {CW{1'b0}};
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == LAST_CNT) begin
                    // End of word: hold buffer first, then a direct load, else go idle.
                    if (hold_full_r) begin
                        shift_s     = hold_r;
                        cnt_s       = {CW{1'b0}};
                        hold_full_s = 1'b0;
                    end else if (xfer_s) begin
                        shift_s = load_bus.data_in;
                        cnt_s   = {CW{1'b0}};
                    end else begin
                        cnt_s   = {CW{1'b0}};
                        state_s = ST_IDLE;
                    end
                end else begin
                    shift_s = advance(shift_r);
                    cnt_s   = cnt_r + CW'(1'b1);
                    if (xfer_s) begin
                        hold_s      = load_bus.data_in;
                        hold_full_s = 1'b1;
                    end else begin
                        hold_full_s = hold_full_r;
                    end
                end
            end
            default: begin
                state_s     = ST_IDLE;
                cnt_s       = {CW{1'b0}};
                hold_full_s = 1'b0;
            end
        endcase
    end

    // Core state registers; reset drops any word in flight.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_r     <= ST_IDLE;
            shift_r     <= {WIDTH{1'b0}};
            cnt_r       <= {CW{1'b0}};
            hold_r      <= {WIDTH{1'b0}};
            hold_full_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            shift_r     <= shift_s;
            cnt_r       <= cnt_s;
            hold_r      <= hold_s;
            hold_full_r <= hold_full_s;
        end
    end

    // Serial outputs registered from next state so A never sees data_in combinationally.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            a_r         <= 1'b0;
            bit_valid_r <= 1'b0;
            last_bit_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            if (state_s == ST_SHIFT) begin
                a_r         <= end_bit(shift_s);
                bit_valid_r <= 1'b1;
                last_bit_r  <= (cnt_s == LAST_CNT);
            end else begin
                a_r         <= 1'b0;
                bit_valid_r <= 1'b0;
                last_bit_r  <= 1'b0;
            end
            busy_r <= (state_s == ST_SHIFT) || hold_full_s;
        end
    end

endmodule
